// File: rtl/perm_inverse_engine_if.sv
// Streaming bus of the permutation engine.
//   abort                : synchronous frame discard (driver -> engine)
//   in_valid/in_ready    : load handshake, in_data = destination of the next
//                          input index, in_mode = 0 forward / 1 inverse
//   out_valid/out_ready  : emit handshake, out_data = entry at the emit index,
//                          out_last marks entry N-1
//   perm_ok              : frame had no duplicate destinations
//   busy                 : a frame is in progress
// master = frame source/sink (testbench or upstream), slave = engine.
interface perm_inverse_engine_if #(
  parameter int LOG_N = 3
) ();
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [LOG_N-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [LOG_N-1:0] out_data;
  logic             out_last;
  logic             perm_ok;
  logic             busy;

  modport master (
    output abort, in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_last, perm_ok, busy
  );

  modport slave (
    input  abort, in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_last, perm_ok, busy
  );
endinterface

// File: rtl/perm_inverse_engine.sv
// Streaming permutation engine for Benes routing control.
// Loads an N-entry destination permutation one entry per beat (LOAD), then
// streams back either the forward table or its inverse (EMIT), flagging
// frames that contained duplicate destinations.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : perm_inverse_engine_if.slave (load/emit handshakes, abort, status)
module perm_inverse_engine #(
  parameter int LOG_N = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  perm_inverse_engine_if.slave  bus
);
  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

  typedef enum logic {S_LOAD, S_EMIT} state_t;

  state_t           state_reg, state_next;
  logic [LOG_N-1:0] ld_idx_reg;
  logic [LOG_N-1:0] em_idx_reg;
  logic             dup_reg;
  logic             mode_reg;

  logic [N-1:0]     seen_vec;
  logic [LOG_N-1:0] fwd_rd [N];
  logic [LOG_N-1:0] inv_rd [N];

  logic load_hs;
  logic emit_hs;
  logic load_done;
  logic frame_done;

  // abort outranks both handshakes; the entry offered alongside it is dropped.
  assign load_hs    = (state_reg == S_LOAD) & bus.in_valid & ~bus.abort;
  assign emit_hs    = (state_reg == S_EMIT) & bus.out_ready & ~bus.abort;
  assign load_done  = load_hs & (ld_idx_reg == LAST_IDX);
  assign frame_done = emit_hs & (em_idx_reg == LAST_IDX);

  // Per-entry storage: forward table, inverse table and the seen flag.
  // inv[] is written by destination, so a duplicate simply overwrites and the
  // last writer wins.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      logic [LOG_N-1:0] fwd_reg;
      logic [LOG_N-1:0] inv_reg;
      logic             seen_reg;

      always_ff @(posedge clk) begin
        if (load_hs && ld_idx_reg == LOG_N'(gi)) begin
          fwd_reg <= bus.in_data;
        end
        if (load_hs && bus.in_data == LOG_N'(gi)) begin
          inv_reg <= ld_idx_reg;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          seen_reg <= 1'b0;
        end else if (bus.abort || frame_done) begin
          seen_reg <= 1'b0;
        end else if (load_hs && bus.in_data == LOG_N'(gi)) begin
          seen_reg <= 1'b1;
        end
      end

      assign fwd_rd[gi]   = fwd_reg;
      assign inv_rd[gi]   = inv_reg;
      assign seen_vec[gi] = seen_reg;
    end
  endgenerate

  // Counters, duplicate flag and frame mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_idx_reg <= '0;
      em_idx_reg <= '0;
      dup_reg    <= 1'b0;
      mode_reg   <= 1'b0;
    end else if (bus.abort) begin
      ld_idx_reg <= '0;
      em_idx_reg <= '0;
      dup_reg    <= 1'b0;
    end else begin
      if (load_hs) begin
        // The counter wraps naturally to 0 after entry N-1.
        ld_idx_reg <= ld_idx_reg + 1'b1;
        dup_reg    <= dup_reg | seen_vec[bus.in_data];
        if (ld_idx_reg == '0) begin
          mode_reg <= bus.in_mode;
        end
      end
      if (emit_hs) begin
        em_idx_reg <= em_idx_reg + 1'b1;
      end
      if (frame_done) begin
        ld_idx_reg <= '0;
        dup_reg    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.perm_ok   = 1'b1;
    bus.busy      = 1'b0;

    if (bus.abort) begin
      state_next = S_LOAD;
    end else begin
      case (state_reg)
        S_LOAD:  if (load_done)  state_next = S_EMIT;
        S_EMIT:  if (frame_done) state_next = S_LOAD;
        default: state_next = S_LOAD;
      endcase
    end

    if (state_reg == S_EMIT) begin
      bus.out_valid = 1'b1;
      bus.out_last  = (em_idx_reg == LAST_IDX);
      bus.perm_ok   = ~dup_reg;
      bus.busy      = 1'b1;
      // Inverse entries whose index was never a destination read as 0.
      if (mode_reg) begin
        bus.out_data = seen_vec[em_idx_reg] ? inv_rd[em_idx_reg] : '0;
      end else begin
        bus.out_data = fwd_rd[em_idx_reg];
      end
    end else begin
      bus.in_ready = ~rst;
      bus.busy     = (ld_idx_reg != '0);
    end
  end
endmodule

// File: tb/tb_perm_inverse_engine.sv
module tb_perm_inverse_engine;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  perm_inverse_engine_if #(.LOG_N(3)) b3 ();
  perm_inverse_engine_if #(.LOG_N(4)) b4 ();

  perm_inverse_engine #(.LOG_N(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
  perm_inverse_engine #(.LOG_N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [2:0] d[8];
    bit         mode;
    logic [2:0] exp[8];
    bit         exp_ok;
  } vec_t;

  typedef struct {
    logic [2:0] d;
    bit         m;
  } beat_t;

  beat_t      tx_q[$];
  logic [2:0] rx_d[$];
  bit         rx_last[$];
  bit         rx_ok[$];
  int         in_stamps[$];
  int         out_stamps[$];

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: forward is the list itself; inverse maps each destination to
  // the last input index that targeted it (0 if never targeted); the frame is
  // a permutation iff every destination occurs exactly once.
  function automatic void model(input logic [2:0] d[8], input bit mode,
                                output logic [2:0] q[8], output bit ok);
    int cnt[8];
    int owner[8];
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      owner[i] = -1;
    end
    for (int i = 0; i < N; i++) begin
      cnt[d[i]]++;
      owner[d[i]] = i;
    end
    ok = 1'b1;
    for (int i = 0; i < N; i++) if (cnt[i] != 1) ok = 1'b0;
    for (int j = 0; j < N; j++)
      q[j] = mode ? ((owner[j] < 0) ? 3'd0 : 3'(owner[j])) : d[j];
  endfunction

  task automatic push_frame(input logic [2:0] d[8], input bit mode);
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.d = d[i];
      b.m = mode;
      tx_q.push_back(b);
    end
  endtask

  task automatic feeder(input int budget);
    int t = 0;
    while (tx_q.size() > 0 && t < budget) begin
      b3.in_valid = 1'b1;
      b3.in_data  = tx_q[0].d;
      b3.in_mode  = tx_q[0].m;
      if (b3.in_ready) begin
        in_stamps.push_back(cyc);
        void'(tx_q.pop_front());
      end
      @(negedge clk);
      t++;
    end
    b3.in_valid = 1'b0;
    chk("feed_timeout", tx_q.size(), 0);
  endtask

  task automatic collector(input int nbeats, input bit rnd, input int budget);
    int         t = 0;
    bit         stalled = 1'b0;
    logic [2:0] held_d = '0;
    bit         held_l = 1'b0;
    while (rx_d.size() < nbeats && t < budget) begin
      b3.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b3.out_valid) begin
        if (stalled) begin
          chk("stall_data", b3.out_data, held_d);
          chk("stall_last", b3.out_last, held_l);
        end
        chk("in_ready_in_emit", b3.in_ready, 0);
        if (b3.out_ready) begin
          rx_d.push_back(b3.out_data);
          rx_last.push_back(b3.out_last);
          rx_ok.push_back(b3.perm_ok);
          out_stamps.push_back(cyc);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = b3.out_data;
          held_l  = b3.out_last;
        end
      end
      @(negedge clk);
      t++;
    end
    b3.out_ready = 1'b0;
    chk("handshake_count", rx_d.size(), nbeats);
  endtask

  task automatic run_stream(input int nbeats, input bit rnd);
    rx_d.delete();
    rx_last.delete();
    rx_ok.delete();
    in_stamps.delete();
    out_stamps.delete();
    fork
      feeder(4000);
      collector(nbeats, rnd, 4000);
    join
    chk("no_extra_valid", b3.out_valid, 0);
  endtask

  task automatic check_frame(input string nm, input logic [2:0] e[8], input bit ok, input int base);
    int nerr = tests_failed;
    for (int j = 0; j < N; j++) begin
      if (base + j < rx_d.size()) begin
        chk({nm, "_data"}, rx_d[base + j], e[j]);
        chk({nm, "_last"}, rx_last[base + j], (j == N - 1));
        chk({nm, "_perm_ok"}, rx_ok[base + j], ok);
      end
    end
    $display("[TB] frame %s checked, %0d new errors", nm, tests_failed - nerr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] d[8];
    logic [2:0] q[8];
    bit         ok;
    bit         mode;
    int         inv4[16];

    vecs[0] = '{name: "inv_basic", d: '{3'd6, 3'd2, 3'd5, 3'd4, 3'd0, 3'd7, 3'd1, 3'd3}, mode: 1'b1,
                exp: '{3'd4, 3'd6, 3'd1, 3'd7, 3'd3, 3'd2, 3'd0, 3'd5}, exp_ok: 1'b1};
    vecs[1] = '{name: "fwd_basic", d: '{3'd6, 3'd2, 3'd5, 3'd4, 3'd0, 3'd7, 3'd1, 3'd3}, mode: 1'b0,
                exp: '{3'd6, 3'd2, 3'd5, 3'd4, 3'd0, 3'd7, 3'd1, 3'd3}, exp_ok: 1'b1};
    vecs[2] = '{name: "inv_dup", d: '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, mode: 1'b1,
                exp: '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, exp_ok: 1'b0};
    vecs[3] = '{name: "after_dup", d: '{3'd6, 3'd2, 3'd5, 3'd4, 3'd0, 3'd7, 3'd1, 3'd3}, mode: 1'b1,
                exp: '{3'd4, 3'd6, 3'd1, 3'd7, 3'd3, 3'd2, 3'd0, 3'd5}, exp_ok: 1'b1};

    b3.abort = 1'b0; b3.in_valid = 1'b0; b3.in_data = '0; b3.in_mode = 1'b0; b3.out_ready = 1'b0;
    b4.abort = 1'b0; b4.in_valid = 1'b0; b4.in_data = '0; b4.in_mode = 1'b0; b4.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", b3.in_ready, 0);
    chk("rst_out_valid", b3.out_valid, 0);
    chk("rst_out_data", b3.out_data, 0);
    chk("rst_out_last", b3.out_last, 0);
    chk("rst_busy", b3.busy, 0);
    chk("rst_perm_ok", b3.perm_ok, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", b3.in_ready, 1);

    // Table-driven single frames, out_ready held high.
    for (int k = 0; k < 4; k++) begin
      push_frame(vecs[k].d, vecs[k].mode);
      run_stream(N, 1'b0);
      check_frame(vecs[k].name, vecs[k].exp, vecs[k].exp_ok, 0);
      if (in_stamps.size() == N && out_stamps.size() == N) begin
        chk("first_out_latency", out_stamps[0] - in_stamps[N - 1], 1);
        chk("emit_no_bubbles", out_stamps[N - 1] - out_stamps[0], N - 1);
      end else begin
        chk("stamp_count", in_stamps.size() + out_stamps.size(), 2 * N);
      end
    end

    // Two back-to-back frames with in_valid held high throughout.
    push_frame(vecs[1].d, 1'b0);
    push_frame(vecs[0].d, 1'b1);
    run_stream(2 * N, 1'b0);
    check_frame("b2b_first", vecs[1].exp, 1'b1, 0);
    check_frame("b2b_second", vecs[0].exp, 1'b1, N);
    if (in_stamps.size() == 2 * N && out_stamps.size() == 2 * N) begin
      chk("b2b_total_cycles", out_stamps[2 * N - 1] - in_stamps[0], 4 * N - 1);
      chk("b2b_reload_gap", in_stamps[N] - out_stamps[N - 1], 1);
    end else begin
      chk("b2b_stamp_count", in_stamps.size() + out_stamps.size(), 4 * N);
    end

    // Random frames with random backpressure against the reference model.
    for (int r = 0; r < 24; r++) begin
      beat_t b;
      for (int i = 0; i < N; i++) d[i] = 3'(i);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = N - 1; i > 0; i--) begin
          int j = $urandom_range(0, i);
          logic [2:0] tmp = d[i];
          d[i] = d[j];
          d[j] = tmp;
        end
      end else begin
        for (int i = 0; i < N; i++) d[i] = 3'($urandom_range(0, N - 1));
      end
      mode = 1'($urandom_range(0, 1));
      model(d, mode, q, ok);
      // Only the first beat's in_mode should matter.
      for (int i = 0; i < N; i++) begin
        b.d = d[i];
        b.m = (i == 0) ? mode : 1'($urandom_range(0, 1));
        tx_q.push_back(b);
      end
      run_stream(N, 1'b1);
      check_frame($sformatf("rand%0d", r), q, ok, 0);
    end

    // Abort after four beats; the entry offered with abort is dropped.
    for (int i = 0; i < 4; i++) begin
      b3.in_valid = 1'b1;
      b3.in_data  = 3'(7 - i);
      b3.in_mode  = 1'b0;
      @(negedge clk);
    end
    chk("busy_mid_load", b3.busy, 1);
    b3.abort   = 1'b1;
    b3.in_data = 3'd7;
    @(negedge clk);
    b3.abort    = 1'b0;
    b3.in_valid = 1'b0;
    chk("abort_busy", b3.busy, 0);
    chk("abort_out_valid", b3.out_valid, 0);
    push_frame(vecs[0].d, 1'b1);
    run_stream(N, 1'b0);
    check_frame("after_abort", vecs[0].exp, 1'b1, 0);

    // Reset in the middle of emitting a duplicate frame.
    push_frame(vecs[2].d, 1'b1);
    feeder(200);
    b3.out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", b3.out_valid, 1);
    chk("pre_rst_perm_ok", b3.perm_ok, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", b3.out_valid, 0);
    chk("midrst_out_data", b3.out_data, 0);
    chk("midrst_out_last", b3.out_last, 0);
    chk("midrst_busy", b3.busy, 0);
    chk("midrst_perm_ok", b3.perm_ok, 1);
    chk("midrst_in_ready", b3.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_in_ready", b3.in_ready, 1);
    @(negedge clk);
    push_frame(vecs[0].d, 1'b1);
    run_stream(N, 1'b0);
    check_frame("after_rst", vecs[0].exp, 1'b1, 0);

    // 16-entry engine: load i -> (5i+3) mod 16 in inverse mode, with in_mode
    // dropping to 0 after the first beat.
    for (int i = 0; i < 16; i++) inv4[(i * 5 + 3) % 16] = i;
    for (int i = 0; i < 16; i++) begin
      b4.in_valid = 1'b1;
      b4.in_data  = 4'((i * 5 + 3) % 16);
      b4.in_mode  = (i == 0);
      chk("n16_in_ready", b4.in_ready, 1);
      @(negedge clk);
    end
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      int t = 0;
      while (!b4.out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("n16_valid", b4.out_valid, 1);
      chk("n16_data", b4.out_data, inv4[j]);
      chk("n16_last", b4.out_last, (j == 15));
      chk("n16_perm_ok", b4.perm_ok, 1);
      @(negedge clk);
    end
    b4.out_ready = 1'b0;
    chk("n16_done_valid", b4.out_valid, 0);
    $display("[TB] frame n16_inverse checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
